// File: rtl/dbus_pkg.sv
// -----------------------------------------------------------------------------
// dbus_pkg
// Shared definitions for the CPU data-bus responder slice:
//   - responder FSM state encoding
//   - default read data returned on a timed-out access
//   - region base addresses of the data-bus map
//   - helper to extract the device word address from a CPU byte address
// No ports (package).
// -----------------------------------------------------------------------------
package dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } dbus_state_t;

  localparam logic [31:0] DBUS_ERR_DATA = 32'hDEADBEEF;

  // Region bases of the data-bus map, as decoded upstream.
  localparam logic [31:0] DBUS_BASE_RAM    = 32'h8000_0000;
  localparam logic [31:0] DBUS_BASE_BOOT   = 32'hBFC0_0000;
  localparam logic [31:0] DBUS_BASE_PERIPH = 32'hBFC0_9000;
  localparam logic [31:0] DBUS_BASE_SDC    = 32'hBFC0_A000;

  // Byte address -> device word address (drops the two byte-lane bits).
  function automatic logic [29:0] dbus_word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/dbus_timeout_ctr.sv
// -----------------------------------------------------------------------------
// dbus_timeout_ctr
// Down-counting request timer. Loaded with TIMEOUT-1 on clear, decrements
// while enabled, and flags expiry in the enabled cycle it sits at zero, so
// expiry lands in the TIMEOUT-th enabled cycle after a clear.
// Ports:
//   clk       in  clock
//   rst       in  synchronous active-high reset
//   clr_i     in  reload the counter (entry to the timed phase)
//   en_i      in  count enable (timed phase active)
//   expire_o  out terminal count reached while enabled
// -----------------------------------------------------------------------------
module dbus_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= CNT_LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/dbus_responder_bridge.sv
// -----------------------------------------------------------------------------
// dbus_responder_bridge
// Slave-side responder for the CPU data bus. Each decoded access (en) is
// turned into one req/ack handshake toward a slow device; the CPU is stalled
// with nak while the handshake is outstanding.
//
// Optional feature: define DBUS_RESP_TIMEOUT_EN to build a request timer.
// After TIMEOUT cycles in REQ without dev_ack the access is force-completed
// (reads return ERR_DATA) and the sticky err flag is set. Without the macro
// REQ waits indefinitely and err stays 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  region enable from the bus decoder
//   addr, we, be, wdata CPU access (byte address, write, byte lanes, data)
//   rdata               read data to the decoder mux
//   nak                 stall, high while in REQ
//   dev_req             device request, held until ack (or timeout)
//   dev_we, dev_be      latched write strobe / byte enables
//   dev_addr            latched word address addr[ADDR_W+1:2]
//   dev_wdata           latched write data
//   dev_ack, dev_rdata  device completion pulse and read data
//   err, err_clr        sticky timeout flag and its clear
// -----------------------------------------------------------------------------
module dbus_responder_bridge
  import dbus_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = DBUS_ERR_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              nak,
  output logic              dev_req,
  output logic              dev_we,
  output logic [3:0]        dev_be,
  output logic [ADDR_W-1:0] dev_addr,
  output logic [31:0]       dev_wdata,
  input  logic              dev_ack,
  input  logic [31:0]       dev_rdata,
  output logic              err,
  input  logic              err_clr
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("dbus_responder_bridge: TIMEOUT must be at least 1");
  end

  dbus_state_t       state_q;
  logic [31:0]       rdata_q;
  logic              dev_req_q;
  logic              dev_we_q;
  logic [3:0]        dev_be_q;
  logic [ADDR_W-1:0] dev_addr_q;
  logic [31:0]       dev_wdata_q;
  logic              err_q;

  logic              accept;
  logic              in_req;
  logic              tmo_expire;
  logic [29:0]       word_addr;
  logic              unused_addr_bits;

  assign word_addr        = dbus_word_addr(addr);
  assign unused_addr_bits = ^word_addr[29:ADDR_W] ^ ^addr[1:0];

  // A new access is taken from IDLE and also straight out of DONE, which is
  // what gives back-to-back accesses a single non-stalled cycle between them.
  assign in_req = (state_q == ST_REQ);
  assign accept = en && !in_req;

`ifdef DBUS_RESP_TIMEOUT_EN
  dbus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept),
    .en_i     (in_req),
    .expire_o (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rdata_q     <= '0;
      dev_req_q   <= 1'b0;
      dev_we_q    <= 1'b0;
      dev_be_q    <= '0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      // Clear first; a timeout in the same cycle overrides it below.
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (en) begin
            dev_we_q    <= we;
            dev_be_q    <= be;
            dev_addr_q  <= word_addr[ADDR_W-1:0];
            dev_wdata_q <= wdata;
            dev_req_q   <= 1'b1;
            state_q     <= ST_REQ;
          end else begin
            state_q     <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // Bus inputs are deliberately not looked at here: the CPU holds
          // them stable during the stall.
          if (dev_ack) begin
            dev_req_q <= 1'b0;
            if (!dev_we_q) begin
              rdata_q <= dev_rdata;
            end
            state_q   <= ST_DONE;
          end else if (tmo_expire) begin
            dev_req_q <= 1'b0;
            if (!dev_we_q) begin
              rdata_q <= ERR_DATA;
            end
            err_q     <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        default: begin
          dev_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign nak       = in_req;
  assign rdata     = rdata_q;
  assign dev_req   = dev_req_q;
  assign dev_we    = dev_we_q;
  assign dev_be    = dev_be_q;
  assign dev_addr  = dev_addr_q;
  assign dev_wdata = dev_wdata_q;
  assign err       = err_q;

endmodule
